// File: rtl/inst_fetch_mem.sv
// Instruction memory with a word-serial program loader and a one-cycle fetch port.
// The loader owns the memory while in LOAD. Fetches are served only in RUN.
module inst_fetch_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_en,
  input  logic                     load_last,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     fetch_ready,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     addr_err,
  output logic                     load_done,
  output logic                     load_ovf,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               full;
  logic               wr_en;
  logic               accept;
  logic [IDX_W-1:0]   idx;
  logic               out_of_range;
  logic               misaligned;
  logic               unloaded;

  // The load pointer doubles as the loaded-word count.
  assign word_count   = ptr;
  assign full         = (ptr == PTR_W'(DEPTH));
  assign wr_en        = (state == LOAD) && load_en && !load_start && !full;
  assign accept       = (state == RUN) && fetch_req;
  assign idx          = fetch_addr[IDX_W+1:2];
  assign out_of_range = (fetch_addr >> (IDX_W + 2)) != '0;
  assign misaligned   = (fetch_addr[1:0] != 2'b00);
  assign unloaded     = ({1'b0, idx} >= ptr);

  // Loader FSM: state, load pointer, completion pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_ready <= 1'b1;
      ptr         <= '0;
      load_done   <= 1'b0;
      load_ovf    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        RUN: begin
          if (load_start) begin
            state       <= LOAD;
            fetch_ready <= 1'b0;
            ptr         <= '0;
            load_ovf    <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            ptr      <= '0;
            load_ovf <= 1'b0;
          end else if (load_en) begin
            if (full) begin
              load_ovf <= 1'b1;
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
            if (load_last) begin
              state       <= RUN;
              fetch_ready <= 1'b1;
              load_done   <= 1'b1;
            end
          end
        end
        default: begin
          state       <= RUN;
          fetch_ready <= 1'b1;
        end
      endcase
    end
  end

  // Program storage; deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr[IDX_W-1:0]] <= load_data;
    end
  end

  // Fetch output registers: flush beats stall, stall beats a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else if (flush) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else if (stall) begin
      instr       <= instr;
      instr_valid <= instr_valid;
      addr_err    <= addr_err;
    end else if (accept) begin
      instr_valid <= 1'b1;
      addr_err    <= misaligned;
      if (misaligned || out_of_range || unloaded) begin
        instr <= '0;
      end else begin
        instr <= mem[idx];
      end
    end else begin
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end
  end

endmodule

// File: doc/inst_fetch_mem.md
INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, instruction word width; ADDR_W, default 32, byte-address width; DEPTH, default 64, word capacity (power of two, 2..1024).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 load_start  in  1  enter LOAD state, load pointer cleared.
REQ-006 load_en  in  1  write load_data at load pointer (LOAD state only).
REQ-007 load_last  in  1  qualifies load_en; final word of program.
REQ-008 load_data  in  DATA_W  program word.
REQ-009 fetch_req  in  1  fetch request.
REQ-010 fetch_addr  in  ADDR_W  byte address of instruction.
REQ-011 stall  in  1  hold fetch output registers.
REQ-012 flush  in  1  invalidate fetch output.
REQ-013 fetch_ready  out  1  high in RUN state.
REQ-014 instr  out  DATA_W  fetched instruction.
REQ-015 instr_valid  out  1  instr is valid.
REQ-016 addr_err  out  1  fetched address misaligned, registered with instr.
REQ-017 load_done  out  1  one-cycle pulse on completion of load.
REQ-018 load_ovf  out  1  sticky: load_en attempted with memory full.
REQ-019 word_count  out  clog2(DEPTH)+1  number of loaded words.

Function
REQ-020 The FSM SHALL have two states: RUN and LOAD; reset state is RUN.
REQ-021 RUN -> LOAD on load_start; in LOAD, load_start SHALL restart: pointer 0, word_count 0, load_ovf cleared.
REQ-022 In LOAD, load_en with pointer < DEPTH SHALL write load_data to word[pointer], increment pointer, and set word_count = pointer+1.
REQ-023 load_en with pointer == DEPTH SHALL not write and SHALL set load_ovf.
REQ-024 load_en with load_last SHALL perform that write (if not full), return to RUN next cycle, and pulse load_done for exactly one cycle.
REQ-025 load_en in RUN SHALL be ignored.
REQ-026 fetch_ready SHALL be 1 in RUN, 0 in LOAD; fetch_req in LOAD SHALL be ignored.
REQ-027 Read latency SHALL be one cycle: fetch_req accepted at edge N gives instr/instr_valid valid after edge N.
REQ-028 Word index SHALL be fetch_addr[clog2(DEPTH)+1:2]; fetch_addr bits above that range SHALL make the address out of range.
REQ-029 Out-of-range addresses or index >= word_count SHALL return instr = 0 with instr_valid = 1.
REQ-030 fetch_addr[1:0] != 0 SHALL return instr = 0, instr_valid = 1, addr_err = 1; otherwise addr_err = 0.
REQ-031 No accepted request (fetch_req = 0 in RUN, or LOAD state) SHALL give instr_valid = 0 next cycle, with instr holding its previous value.
REQ-032 stall = 1 SHALL hold instr, instr_valid, and addr_err unchanged, and the concurrent request SHALL be discarded.
REQ-033 flush = 1 SHALL set instr = 0, instr_valid = 0, and addr_err = 0 next cycle; flush SHALL win over stall and fetch_req.
REQ-034 A write and a fetch to the same word in one cycle cannot occur, because fetch is disabled in LOAD.

Reset
REQ-035 rst SHALL set: state RUN, pointer 0, word_count 0, instr 0, instr_valid 0, addr_err 0, load_done 0, load_ovf 0.
REQ-036 Memory array contents SHALL NOT be altered by rst; they are unreadable until reloaded because word_count = 0.
REQ-037 rst asserted mid-load SHALL abort the load with no load_done pulse; rst SHALL take priority over all inputs.

Verification
REQ-038 Load 3 words 0xE3A00014, 0xE3A01A01, 0xE3A02103 (last on third) -> load_done pulses once, word_count=3; fetch 0,4,8 -> those words one cycle later, instr_valid=1.
REQ-039 After REQ-038, fetch 12 and fetch 4*DEPTH -> instr=0, instr_valid=1, addr_err=0.
REQ-040 Fetch 0x2 -> instr=0, instr_valid=1, addr_err=1.
REQ-041 Fetch 0 then stall 2 cycles with requests at 4 -> instr stays 0xE3A00014; same with stall+flush -> instr=0, instr_valid=0.
REQ-042 Load DEPTH+1 words (load_last on last) -> load_ovf=1, word_count=DEPTH, word[0] intact.
REQ-043 rst after 2 of 3 load writes -> fetch_ready=1, word_count=0, no load_done; fetch 0 -> instr=0.
